// File: rtl/posit_add_arbiter.sv
// rtl/posit_add_arbiter.sv - round-robin arbiter sharing one pipelined posit adder among NREQ requesters
// Optional per-requester grant and stall statistics are compiled in with POSIT_ARB_STATS_EN.
module posit_add_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = 8,
  parameter int MAX_OUT     = 4,
  parameter int TAG_DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_in1,
  input  logic [32*NREQ-1:0] req_in2,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_result,
  output logic               rsp_inf,
  output logic               rsp_zero,
  output logic [31:0]        add_in1,
  output logic [31:0]        add_in2,
  output logic               add_start,
  input  logic [31:0]        add_result,
  input  logic               add_inf,
  input  logic               add_zero,
  input  logic               add_done,
  output logic               busy,
  output logic               err_unexpected_done
`ifdef POSIT_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0] grant_count,
  output logic [15:0]        stall_count
`endif
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = TW + 1;
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int BW = $clog2(ADD_LATENCY + 2);
  localparam logic [BW-1:0] BLANK_INIT = BW'(ADD_LATENCY + 1);
  localparam logic [AW-1:0] PTR_LAST   = AW'(TAG_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(TAG_DEPTH);
  localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUT);
  localparam logic [TW-1:0] IDX_LAST   = TW'(NREQ - 1);
  localparam logic [SW-1:0] NREQ_W     = SW'(NREQ);

  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] grant_idx;
  logic          grant_any;
  logic [SW-1:0] arb_sum;
  logic [TW-1:0] arb_cand;
  logic [OW-1:0] out_cnt [NREQ];
  logic [TW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [BW-1:0] blank_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          blanking;
  logic          push;
  logic          pop;

  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign fifo_empty = (fifo_cnt == '0);
  assign blanking   = (blank_cnt != '0);
  assign busy       = !fifo_empty || blanking;
  assign push       = grant_any;
  // The adder pipeline is not reset, so done pulses seen during blanking are stale.
  assign pop        = add_done && !fifo_empty && !blanking;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    arb_sum   = '0;
    arb_cand  = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_sum = {1'b0, rr_ptr} + SW'(k);
      if (arb_sum >= NREQ_W) arb_sum = arb_sum - NREQ_W;
      arb_cand = arb_sum[TW-1:0];
      if (!grant_any && req_valid[arb_cand] && (out_cnt[arb_cand] < OUT_MAX) &&
          !fifo_full && !blanking) begin
        grant_any = 1'b1;
        grant_idx = arb_cand;
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_cnt            <= '0;
      blank_cnt           <= BLANK_INIT;
      add_start           <= 1'b0;
      add_in1             <= '0;
      add_in2             <= '0;
      rsp_valid           <= '0;
      rsp_result          <= '0;
      rsp_inf             <= 1'b0;
      rsp_zero            <= 1'b0;
      err_unexpected_done <= 1'b0;
    end else begin
      add_start <= push;
      if (push) begin
        add_in1 <= req_in1[32*grant_idx +: 32];
        add_in2 <= req_in2[32*grant_idx +: 32];
        rr_ptr  <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
        wr_ptr  <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop) fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (blanking) blank_cnt <= blank_cnt - 1'b1;
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[tag_mem[rd_ptr]] <= 1'b1;
        rsp_result                 <= add_result;
        rsp_inf                    <= add_inf;
        rsp_zero                   <= add_zero;
      end
      if (add_done && fifo_empty && !blanking) err_unexpected_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push && (grant_idx == TW'(i)) && !rsp_valid[i]) out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (!(push && (grant_idx == TW'(i))) && rsp_valid[i]) out_cnt[i] <= out_cnt[i] - 1'b1;
      end
    end
  end

`ifdef POSIT_ARB_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      stall_count <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push && (grant_idx == TW'(i)) && (grant_cnt[i] != 16'hFFFF))
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if ((|req_valid) && !push && (stall_count != 16'hFFFF)) stall_count <= stall_count + 1'b1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_grant_count
    assign grant_count[16*g +: 16] = grant_cnt[g];
  end
`endif
endmodule

// File: tb/tb_posit_add_arbiter.sv
// tb/tb_posit_add_arbiter.sv - directed self-checking bench for posit_add_arbiter
// A small non-resettable pipeline model stands in for the posit adder.
module tb_posit_add_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_in1 = {32'hC0000000, 32'h80000000, 32'h40000000, 32'h40000000};
  logic [127:0] req_in2 = {32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000};
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_result;
  logic         rsp_inf;
  logic         rsp_zero;
  logic [31:0]  add_in1;
  logic [31:0]  add_in2;
  logic         add_start;
  logic [31:0]  add_result;
  logic         add_inf;
  logic         add_zero;
  logic         add_done;
  logic         busy;
  logic         err_unexpected_done;
`ifdef POSIT_ARB_STATS_EN
  logic [63:0]  grant_count;
  logic [15:0]  stall_count;
`endif

  logic         inj_done = 1'b0;
  logic [31:0]  inj_val = '0;
  logic [LAT-1:0] pv = '0;
  logic [31:0]  pr [LAT];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int g_cyc[$];
  int g_idx[$];
  int s_cyc[$];
  logic [31:0] s_in1[$];
  int r_cyc[$];
  logic [3:0]  r_mask[$];
  logic [31:0] r_res[$];
  logic        r_inf[$];
  logic        r_zero[$];

  // Hand-computed posit32 sums of each requester's fixed operands: 1+1, 1+0, NaR+0, -1+1.
  logic [31:0] exp_res  [4] = '{32'h48000000, 32'h40000000, 32'h80000000, 32'h00000000};
  logic        exp_inf  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic        exp_zero [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  posit_add_arbiter #(.NREQ(NREQ), .ADD_LATENCY(LAT), .MAX_OUT(4), .TAG_DEPTH(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_in1             (req_in1),
    .req_in2             (req_in2),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_result          (rsp_result),
    .rsp_inf             (rsp_inf),
    .rsp_zero            (rsp_zero),
    .add_in1             (add_in1),
    .add_in2             (add_in2),
    .add_start           (add_start),
    .add_result          (add_result),
    .add_inf             (add_inf),
    .add_zero            (add_zero),
    .add_done            (add_done),
    .busy                (busy),
    .err_unexpected_done (err_unexpected_done)
`ifdef POSIT_ARB_STATS_EN
    ,
    .grant_count         (grant_count),
    .stall_count         (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] posit_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h48000000;
    if (a == 32'h80000000 || b == 32'h80000000) return 32'h80000000;
    return a + b;
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], add_start};
    pr[0] <= posit_fn(add_in1, add_in2);
    for (int k = 1; k < LAT; k++) pr[k] <= pr[k-1];
  end

  assign add_done   = pv[LAT-1] | inj_done;
  assign add_result = inj_done ? inj_val : pr[LAT-1];
  assign add_inf    = (add_result == 32'h80000000);
  assign add_zero   = (add_result == 32'h00000000);

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        g_cyc.push_back(cyc);
        g_idx.push_back(i);
      end
    end
    if (add_start) begin
      s_cyc.push_back(cyc);
      s_in1.push_back(add_in1);
    end
    if (rsp_valid != 4'h0) begin
      r_cyc.push_back(cyc);
      r_mask.push_back(rsp_valid);
      r_res.push_back(rsp_result);
      r_inf.push_back(rsp_inf);
      r_zero.push_back(rsp_zero);
    end
    if (add_done) done_cnt++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_cyc.delete(); g_idx.delete(); s_cyc.delete(); s_in1.delete();
    r_cyc.delete(); r_mask.delete(); r_res.delete(); r_inf.delete(); r_zero.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    next();
    next();
    reset = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    tests++;
    if (add_start !== 1'b0 || rsp_valid !== 4'h0 || rsp_result !== 32'h0 || rsp_inf !== 1'b0 || rsp_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs add_start=%b rsp_valid=%h rsp_result=%h inf=%b zero=%b required all 0",
               add_start, rsp_valid, rsp_result, rsp_inf, rsp_zero);
    end
    tests++;
    if (err_unexpected_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_err got %b required 0", err_unexpected_done);
    end
    tests++;
    if (req_ready !== 4'h0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_busy req_ready=%h busy=%b required 0 and 1", req_ready, busy);
    end
    next();
    req_valid = '0;
    next();
    reset = 1'b0;
    count_busy(n);
    tests++;
    if (n != 9) begin
      fails++;
      $display("FAIL blank_cycles got %0d required 9", n);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    count_busy(n);
    clear_logs();
    next();
    req_valid = 4'h1;
    next();
    req_valid = '0;
    wait_idle();
    tests++;
    if (g_cyc.size() != 1 || s_cyc.size() != 1 || r_cyc.size() != 1) begin
      fails++;
      $display("FAIL single_counts grants=%0d starts=%0d rsps=%0d required 1 1 1", g_cyc.size(), s_cyc.size(), r_cyc.size());
    end else begin
      tests++;
      if (s_cyc[0] != g_cyc[0] + 1 || s_in1[0] !== 32'h40000000) begin
        fails++;
        $display("FAIL single_start start_cyc=%0d in1=%h required %0d 40000000", s_cyc[0], s_in1[0], g_cyc[0] + 1);
      end
      tests++;
      if (r_cyc[0] != g_cyc[0] + LAT + 2) begin
        fails++;
        $display("FAIL single_latency got %0d required %0d", r_cyc[0] - g_cyc[0], LAT + 2);
      end
      tests++;
      if (r_mask[0] !== 4'h1 || r_res[0] !== 32'h48000000 || r_inf[0] !== 1'b0 || r_zero[0] !== 1'b0) begin
        fails++;
        $display("FAIL single_rsp mask=%h result=%h inf=%b zero=%b required 1 48000000 0 0", r_mask[0], r_res[0], r_inf[0], r_zero[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] m;
    do_reset();
    count_busy(n);
    clear_logs();
    next();
    req_valid = 4'hF;
    repeat (8) next();
    req_valid = '0;
    wait_idle();
    tests++;
    if (g_cyc.size() != 8 || s_cyc.size() != 8 || r_cyc.size() != 8) begin
      fails++;
      $display("FAIL rr_counts grants=%0d starts=%0d rsps=%0d required 8 8 8", g_cyc.size(), s_cyc.size(), r_cyc.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        m = 4'b0001 << (k % 4);
        tests++;
        if (g_idx[k] != k % 4 || g_cyc[k] != g_cyc[0] + k) begin
          fail_line("rr_grant", k, g_idx[k], k % 4);
        end
        tests++;
        if (s_cyc[k] != g_cyc[k] + 1) begin
          fail_line("rr_start_cycle", k, s_cyc[k], g_cyc[k] + 1);
        end
        tests++;
        if (r_mask[k] !== m || r_res[k] !== exp_res[k % 4] || r_inf[k] !== exp_inf[k % 4] ||
            r_zero[k] !== exp_zero[k % 4] || r_cyc[k] != g_cyc[k] + LAT + 2) begin
          fails++;
          $display("FAIL rr_rsp %0d mask=%h result=%h inf=%b zero=%b cyc=%0d required %h %h %b %b %0d",
                   k, r_mask[k], r_res[k], r_inf[k], r_zero[k], r_cyc[k],
                   m, exp_res[k % 4], exp_inf[k % 4], exp_zero[k % 4], g_cyc[k] + LAT + 2);
        end
      end
    end
`ifdef POSIT_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      tests++;
      if (grant_count[16*i +: 16] !== 16'd2) begin
        fails++;
        $display("FAIL stats_grant %0d got %0d required 2", i, grant_count[16*i +: 16]);
      end
    end
    tests++;
    if (stall_count !== 16'd0) begin
      fails++;
      $display("FAIL stats_stall got %0d required 0", stall_count);
    end
`endif
  endtask

  // Counted as a failure by the caller's own tests/fails bookkeeping.
  task automatic fail_line(input string name, input int k, input int got, input int req);
    fails++;
    $display("FAIL %s %0d got %0d required %0d", name, k, got, req);
  endtask

  task automatic test_max_out();
    int n;
    do_reset();
    count_busy(n);
    clear_logs();
    next();
    req_valid = 4'h4;
    repeat (16) next();
    req_valid = '0;
    wait_idle();
    tests++;
    if (g_cyc.size() < 5 || r_cyc.size() < 1) begin
      fails++;
      $display("FAIL maxout_counts grants=%0d rsps=%0d required >=5 >=1", g_cyc.size(), r_cyc.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        tests++;
        if (g_cyc[k] != g_cyc[0] + k) fail_line("maxout_burst", k, g_cyc[k] - g_cyc[0], k);
      end
      tests++;
      if (g_cyc[4] != g_cyc[0] + LAT + 3) fail_line("maxout_regrant", 4, g_cyc[4] - g_cyc[0], LAT + 3);
      tests++;
      if (r_cyc[0] != g_cyc[0] + LAT + 2 || r_mask[0] !== 4'h4) begin
        fails++;
        $display("FAIL maxout_first_rsp cyc=%0d mask=%h required %0d 4", r_cyc[0] - g_cyc[0], r_mask[0], LAT + 2);
      end
      tests++;
      if (r_cyc.size() != g_cyc.size()) fail_line("maxout_rsp_total", 0, r_cyc.size(), g_cyc.size());
      for (int k = 0; k < g_idx.size(); k++) begin
        tests++;
        if (g_idx[k] != 2) fail_line("maxout_idx", k, g_idx[k], 2);
      end
    end
  endtask

  task automatic test_unexpected_done();
    int n;
    do_reset();
    clear_logs();
    repeat (3) next();
    inj_val  = 32'h12345678;
    inj_done = 1'b1;
    next();
    inj_done = 1'b0;
    repeat (16) next();
    tests++;
    if (err_unexpected_done !== 1'b0 || r_cyc.size() != 0) begin
      fails++;
      $display("FAIL blank_done_ignored err=%b rsps=%0d required 0 0", err_unexpected_done, r_cyc.size());
    end
    inj_done = 1'b1;
    next();
    inj_done = 1'b0;
    @(negedge clk);
    tests++;
    if (err_unexpected_done !== 1'b1 || rsp_valid !== 4'h0) begin
      fails++;
      $display("FAIL unexpected_done err=%b rsp_valid=%h required 1 0", err_unexpected_done, rsp_valid);
    end
    repeat (5) next();
    tests++;
    if (err_unexpected_done !== 1'b1 || r_cyc.size() != 0) begin
      fails++;
      $display("FAIL err_sticky err=%b rsps=%0d required 1 0", err_unexpected_done, r_cyc.size());
    end
    reset = 1'b1;
    #1;
    tests++;
    if (err_unexpected_done !== 1'b0) begin
      fails++;
      $display("FAIL err_cleared got %b required 0", err_unexpected_done);
    end
    next();
    next();
    reset = 1'b0;
    count_busy(n);
  endtask

  task automatic test_reset_mid();
    int n;
    int d0;
    do_reset();
    count_busy(n);
    next();
    clear_logs();
    d0 = done_cnt;
    req_valid = 4'h3;
    next();
    next();
    req_valid = '0;
    repeat (3) next();
    tests++;
    if (s_cyc.size() != 2) fail_line("mid_issues", 0, s_cyc.size(), 2);
    reset = 1'b1;
    next();
    next();
    reset = 1'b0;
    count_busy(n);
    tests++;
    if (n != 9) fail_line("mid_busy_drop", 0, n, 9);
    repeat (5) next();
    tests++;
    if (done_cnt - d0 != 2) fail_line("mid_done_pulses", 0, done_cnt - d0, 2);
    tests++;
    if (r_cyc.size() != 0 || err_unexpected_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_discard rsps=%0d err=%b required 0 0", r_cyc.size(), err_unexpected_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_max_out();
    test_unexpected_done();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
